// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the programmable clock divider:
//   MIN_DIV        smallest divide ratio the counter supports (applied ratios
//                  below this are raised to it)
//   CNT_W_DEFAULT  default width of the ratio/counter datapath
//   high_len(N)    number of high cycles in one divided period, ceil(N/2)
//   state_t        IDLE/RUN run state
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int unsigned MIN_DIV       = 2;
  localparam int          CNT_W_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Odd ratios put the extra cycle in the high phase.
  function automatic int unsigned high_len(input int unsigned n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div_if.sv
// -----------------------------------------------------------------------------
// clk_div_if
// Control/status bundle of the programmable clock divider.
//   en        run enable                      (master -> slave)
//   div_val   requested divide ratio N        (master -> slave)
//   div_load  one-cycle load strobe           (master -> slave)
//   div_ack   one-cycle "new ratio active"    (slave -> master)
//   tick      one-cycle pulse per period      (slave -> master)
//   clk_out   divided clock level             (slave -> master)
//   count     current phase counter           (slave -> master)
//   err       sticky clamp flag, only when CLK_DIV_ERR_EN is defined
// Optional feature macro: CLK_DIV_ERR_EN
// -----------------------------------------------------------------------------
interface clk_div_if #(
  parameter int CNT_W = 16
);

  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             tick;
  logic             clk_out;
  logic [CNT_W-1:0] count;
`ifdef CLK_DIV_ERR_EN
  logic             err;
`endif

`ifdef CLK_DIV_ERR_EN
  modport master (
    output en, div_val, div_load,
    input  div_ack, tick, clk_out, count, err
  );

  modport slave (
    input  en, div_val, div_load,
    output div_ack, tick, clk_out, count, err
  );
`else
  modport master (
    output en, div_val, div_load,
    input  div_ack, tick, clk_out, count
  );

  modport slave (
    input  en, div_val, div_load,
    output div_ack, tick, clk_out, count
  );
`endif

endinterface

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
// Runtime-programmable clock divider. Produces a registered divided clock
// level (clk_out, period N, high for ceil(N/2) cycles) and a one-cycle tick
// per period. A new ratio is staged with div_load and only becomes active at
// a period boundary (or immediately while idle), acknowledged by div_ack.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    clk_div_if.slave: en, div_val, div_load in;
//          div_ack, tick, clk_out, count (and err) out
// Parameters:
//   CNT_W        ratio/counter width (at most 32)
//   DEFAULT_DIV  ratio active after reset, 2 .. 2^CNT_W-1
// Optional feature macro: CLK_DIV_ERR_EN adds the sticky err output, set when
// a ratio below 2 is applied (and clamped to 2).
// -----------------------------------------------------------------------------
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = 256
) (
  input  logic      clk,
  input  logic      reset,
  clk_div_if.slave  bus
);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    return (v < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : v;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] count_p0;
  logic [CNT_W-1:0] n_act;
  logic [CNT_W-1:0] pend_val;
  logic             pend;
  logic             clk_out_p1;
  logic             tick_p1;
  logic             div_ack_p1;
`ifdef CLK_DIV_ERR_EN
  logic             err_p1;
`endif

  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] new_val;
  logic             wrap;
  logic             apply_now;

  // Stage p0: phase counter and ratio-apply decision
  always_comb begin
    cur       = (state == ST_RUN) ? count_p0 : '0;
    last      = n_act - CNT_W'(1);
    wrap      = bus.en && (cur == last);
    new_val   = bus.div_load ? bus.div_val : pend_val;
    apply_now = (pend || bus.div_load) && (!bus.en || wrap);
  end

  always_ff @(posedge clk) begin
    if (bus.div_load) begin
      pend_val <= bus.div_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      count_p0   <= '0;
      n_act      <= CNT_W'(DEFAULT_DIV);
      pend       <= 1'b0;
      clk_out_p1 <= 1'b0;
      tick_p1    <= 1'b0;
      div_ack_p1 <= 1'b0;
`ifdef CLK_DIV_ERR_EN
      err_p1     <= 1'b0;
`endif
    end else begin
      state <= bus.en ? ST_RUN : ST_IDLE;

      // Stage p1: registered outputs, one cycle behind the counter
      if (bus.en) begin
        count_p0   <= wrap ? '0 : cur + CNT_W'(1);
        clk_out_p1 <= (32'(cur) < high_len(32'(n_act)));
        tick_p1    <= wrap;
      end else begin
        count_p0   <= '0;
        clk_out_p1 <= 1'b0;
        tick_p1    <= 1'b0;
      end

      div_ack_p1 <= apply_now;
      if (apply_now) begin
        n_act <= clamp_div(new_val);
        pend  <= 1'b0;
`ifdef CLK_DIV_ERR_EN
        if (new_val < CNT_W'(MIN_DIV)) begin
          err_p1 <= 1'b1;
        end
`endif
      end else if (bus.div_load) begin
        pend <= 1'b1;
      end
    end
  end

  assign bus.count   = count_p0;
  assign bus.clk_out = clk_out_p1;
  assign bus.tick    = tick_p1;
  assign bus.div_ack = div_ack_p1;
`ifdef CLK_DIV_ERR_EN
  assign bus.err     = err_p1;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
// Self-checking bench for clk_div_prog: a per-cycle vector table for the
// ratio-change, enable and clamp sequences, plus hand-written sequences for
// reset and the default ratio.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

  localparam int CNT_W = 16;

  typedef struct {
    logic       en;
    logic       ld;
    int         val;
    logic       clk_o;
    logic       tick;
    logic       ack;
    int         cnt;
    logic       err;
  } vec_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  vec_t tbl[$];

  clk_div_if #(.CNT_W(CNT_W)) bus ();

  clk_div_prog #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(256)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic add(input logic en, input logic ld, input int val,
                     input logic c, input logic t, input logic a,
                     input int cnt, input logic e);
    vec_t v;
    v.en = en; v.ld = ld; v.val = val; v.clk_o = c; v.tick = t;
    v.ack = a; v.cnt = cnt; v.err = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic en, input logic ld, input int val);
    bus.en       = en;
    bus.div_load = ld;
    bus.div_val  = CNT_W'(val);
  endtask

  initial begin
    int cyc;
    int highs;
    bit seen;

    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 0);

    //   en ld val   clk tick ack cnt err
    add(0, 1, 4,    0, 0, 1, 0, 0);  // load 4 while idle: applies at once
    add(1, 0, 0,    1, 0, 0, 1, 0);  // first rise one cycle after en
    add(1, 0, 0,    1, 0, 0, 2, 0);
    add(1, 0, 0,    0, 0, 0, 3, 0);
    add(1, 0, 0,    0, 1, 0, 0, 0);
    add(1, 0, 0,    1, 0, 0, 1, 0);
    add(1, 0, 0,    1, 0, 0, 2, 0);
    add(1, 1, 5,    0, 0, 0, 3, 0);  // load 5 mid-period
    add(1, 0, 0,    0, 1, 1, 0, 0);  // old period ends at 4, ack at wrap
    add(1, 0, 0,    1, 0, 0, 1, 0);  // N=5: high 3, low 2
    add(1, 0, 0,    1, 0, 0, 2, 0);
    add(1, 0, 0,    1, 0, 0, 3, 0);
    add(1, 0, 0,    0, 0, 0, 4, 0);
    add(1, 0, 0,    0, 1, 0, 0, 0);
    add(1, 1, 6,    1, 0, 0, 1, 0);  // load 6 ...
    add(1, 1, 8,    1, 0, 0, 2, 0);  // ... then 8 overwrites it
    add(1, 0, 0,    1, 0, 0, 3, 0);
    add(1, 0, 0,    0, 0, 0, 4, 0);
    add(1, 0, 0,    0, 1, 1, 0, 0);  // single ack, N=8
    add(1, 0, 0,    1, 0, 0, 1, 0);
    add(1, 0, 0,    1, 0, 0, 2, 0);
    add(1, 0, 0,    1, 0, 0, 3, 0);
    add(1, 0, 0,    1, 0, 0, 4, 0);
    add(1, 0, 0,    0, 0, 0, 5, 0);
    add(1, 0, 0,    0, 0, 0, 6, 0);
    add(1, 0, 0,    0, 0, 0, 7, 0);
    add(1, 1, 4,    0, 1, 1, 0, 0);  // load on the wrap edge: applied there
    add(1, 0, 0,    1, 0, 0, 1, 0);
    add(1, 0, 0,    1, 0, 0, 2, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0);  // en dropped at count=2
    add(0, 0, 0,    0, 0, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0);
    add(1, 0, 0,    1, 0, 0, 1, 0);  // restart from 0
    add(1, 0, 0,    1, 0, 0, 2, 0);
    add(1, 0, 0,    0, 0, 0, 3, 0);
    add(1, 0, 0,    0, 1, 0, 0, 0);
    add(1, 1, 3,    1, 0, 0, 1, 0);  // pending 3 ...
    add(0, 0, 0,    0, 0, 1, 0, 0);  // ... applied when en drops, no tick
    add(1, 0, 0,    1, 0, 0, 1, 0);  // N=3: high 2, low 1
    add(1, 0, 0,    1, 0, 0, 2, 0);
    add(1, 0, 0,    0, 1, 0, 0, 0);
    add(1, 1, 1,    1, 0, 0, 1, 0);  // load 1 -> clamped to 2
    add(1, 0, 0,    1, 0, 0, 2, 0);
    add(1, 0, 0,    0, 1, 1, 0, 1);
    add(1, 0, 0,    1, 0, 0, 1, 1);  // N=2 toggles each cycle
    add(1, 0, 0,    0, 1, 0, 0, 1);
    add(1, 0, 0,    1, 0, 0, 1, 1);
    add(1, 0, 0,    0, 1, 0, 0, 1);
    add(1, 1, 0,    1, 0, 0, 1, 1);  // load 0 -> clamped to 2
    add(1, 0, 0,    0, 1, 1, 0, 1);
    add(1, 0, 0,    1, 0, 0, 1, 1);

    // Reset state
    step();
    step();
    chk("reset count", int'(bus.count), 0);
    chk("reset clk_out", int'(bus.clk_out), 0);
    chk("reset tick", int'(bus.tick), 0);
    chk("reset div_ack", int'(bus.div_ack), 0);
    reset = 1'b0;
    step();
    chk("idle after reset clk_out", int'(bus.clk_out), 0);

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].ld, tbl[i].val);
      step();
      chk($sformatf("row%0d clk_out", i), int'(bus.clk_out), int'(tbl[i].clk_o));
      chk($sformatf("row%0d tick", i), int'(bus.tick), int'(tbl[i].tick));
      chk($sformatf("row%0d div_ack", i), int'(bus.div_ack), int'(tbl[i].ack));
      chk($sformatf("row%0d count", i), int'(bus.count), tbl[i].cnt);
`ifdef CLK_DIV_ERR_EN
      chk($sformatf("row%0d err", i), int'(bus.err), int'(tbl[i].err));
`endif
    end

    // Reset mid-period with a load pending
    drive(1'b0, 1'b1, 6);
    step();
    chk("preload ack", int'(bus.div_ack), 1);
    drive(1'b1, 1'b0, 0);
    step();
    step();
    drive(1'b1, 1'b1, 10);
    step();
    chk("pre-reset count", int'(bus.count), 3);
    drive(1'b1, 1'b0, 0);
    reset = 1'b1;
    step();
    chk("midreset count", int'(bus.count), 0);
    chk("midreset clk_out", int'(bus.clk_out), 0);
    chk("midreset tick", int'(bus.tick), 0);
    chk("midreset div_ack", int'(bus.div_ack), 0);
`ifdef CLK_DIV_ERR_EN
    chk("midreset err", int'(bus.err), 0);
`endif
    reset = 1'b0;
    drive(1'b0, 1'b0, 0);
    step();
    chk("pending cleared by reset", int'(bus.div_ack), 0);

    // Default ratio 256: tick on the 256th cycle, 128 high cycles before it
    drive(1'b1, 1'b0, 0);
    cyc = 0;
    highs = 0;
    seen = 1'b0;
    for (int k = 1; k <= 300 && !seen; k++) begin
      step();
      if (bus.tick) begin
        seen = 1'b1;
        cyc = k;
      end else if (bus.clk_out) begin
        highs++;
      end
      if (bus.div_ack) chk("no ack at default ratio", 1, 0);
    end
    chk("N=256 tick period", seen ? cyc : -1, 256);
    chk("N=256 high cycles", highs, 128);

    drive(1'b0, 1'b0, 0);
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
